// File: rtl/hamming_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hamming_pkg
// Brief    : Shared Hamming(7,4) widths, parity positions, FSM encoding and
//            the reference encode function used by encoder and decoder benches.
// Revision : 1.0  initial release
// ============================================================================
package hamming_pkg;

    localparam int CODE_W  = 7;
    localparam int DATA_W  = 4;

    localparam int P0_IDX  = 0;
    localparam int P1_IDX  = 1;
    localparam int P2_IDX  = 2;

    localparam int STATE_W = 2;
    localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] ST_SHIFT = 2'd1;
    localparam logic [STATE_W-1:0] ST_GAP   = 2'd2;

    // Codeword layout {d3,d2,d1,d0,p2,p1,p0}
    function automatic logic [CODE_W-1:0] encode74(input logic [DATA_W-1:0] data);
        logic [CODE_W-1:0] code;
        code         = {data, 3'b000};
        code[P2_IDX] = data[3] ^ data[2] ^ data[1];
        code[P1_IDX] = data[3] ^ data[2] ^ data[0];
        code[P0_IDX] = data[3] ^ data[1] ^ data[0];
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hamming_encoder_74.sv
`default_nettype none
// ============================================================================
// Module   : hamming_encoder_74
// Brief    : Combinational Hamming(7,4) encoder.
// Revision : 1.0  initial release
// ============================================================================
module hamming_encoder_74
    import hamming_pkg::*;
(
    input  logic [DATA_W-1:0] i_dataWord,
    output logic [CODE_W-1:0] o_codeWord
);

    assign o_codeWord = encode74(i_dataWord);

endmodule
`default_nettype wire

// File: rtl/hamming_tx_encoder.sv
`default_nettype none
// ============================================================================
// Module   : hamming_tx_encoder
// Brief    : FIFO-buffered Hamming(7,4) transmitter with a parallel codeword
//            strobe and an MSB-first serial stream. Defining
//            HAMMING_ERR_INJECT_EN adds a single-bit error injector.
// Revision : 1.0  initial release
// ============================================================================
module hamming_tx_encoder
    import hamming_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int BIT_PERIOD = 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [DATA_W-1:0] DataIn,
    input  logic              DataValid,
`ifdef HAMMING_ERR_INJECT_EN
    input  logic              InjectEn,
    input  logic [2:0]        InjectPos,
`endif
    output logic              DataReady,
    output logic [CODE_W-1:0] CodeOut,
    output logic              CodeValid,
    output logic              SerialOut,
    output logic              BitValid,
    output logic              FrameStart,
    output logic              Busy
);

    localparam int                c_AW       = $clog2(DEPTH);
    localparam int                c_PW       = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
    localparam logic [c_AW:0]     c_FULL     = (c_AW + 1)'(DEPTH);
    localparam logic [c_PW-1:0]   c_PER_LOAD = c_PW'(BIT_PERIOD - 1);
    localparam logic [2:0]        c_TOP_BIT  = 3'(CODE_W - 1);

    logic [DATA_W-1:0]  r_fifoMem [DEPTH];
    logic [c_AW-1:0]    r_wrPtr;
    logic [c_AW-1:0]    r_rdPtr;
    logic [c_AW:0]      r_count;
    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_nextState;
    logic [2:0]         r_bitCnt;
    logic [c_PW-1:0]    r_perCnt;
    logic [CODE_W-1:0]  r_codeOut;
    logic               r_codeValid;
    logic               r_frameStart;

    logic               w_push;
    logic               w_pop;
    logic               w_empty;
    logic               w_bitEnd;
    logic               w_lastTick;
    logic [CODE_W-1:0]  w_headCode;
    logic [CODE_W-1:0]  w_injMask;
    logic [CODE_W-1:0]  w_loadCode;

    assign w_empty    = (r_count == '0);
    assign DataReady  = (r_count != c_FULL);
    assign w_push     = DataValid && DataReady;
    assign w_pop      = (r_state == ST_IDLE) && !w_empty;
    assign w_bitEnd   = (r_perCnt == '0);
    assign w_lastTick = w_bitEnd && (r_bitCnt == '0);

    always_ff @(posedge Clock) begin
        if (w_push) begin
            r_fifoMem[r_wrPtr] <= DataIn;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + c_AW'(1);
            if (w_pop)  r_rdPtr <= r_rdPtr + c_AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_AW + 1)'(1);
                2'b01:   r_count <= r_count - (c_AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    hamming_encoder_74 u_encoder (
        .i_dataWord (r_fifoMem[r_rdPtr]),
        .o_codeWord (w_headCode)
    );

`ifdef HAMMING_ERR_INJECT_EN
    // Position p flips bit p-1, matching the decoder's error-position report
    always_comb begin
        w_injMask = '0;
        if (InjectEn && (InjectPos != 3'd0)) begin
            w_injMask = CODE_W'(1) << (InjectPos - 3'd1);
        end
    end
`else
    assign w_injMask = '0;
`endif

    assign w_loadCode = w_headCode ^ w_injMask;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE:  if (!w_empty)   w_nextState = ST_SHIFT;
            ST_SHIFT: if (w_lastTick) w_nextState = ST_GAP;
            ST_GAP:   w_nextState = ST_IDLE;
            default:  w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_codeOut    <= '0;
            r_codeValid  <= 1'b0;
            r_frameStart <= 1'b0;
            r_bitCnt     <= '0;
            r_perCnt     <= '0;
        end else begin
            r_codeValid  <= w_pop;
            r_frameStart <= w_pop;
            if (w_pop) begin
                r_codeOut <= w_loadCode;
                r_bitCnt  <= c_TOP_BIT;
                r_perCnt  <= c_PER_LOAD;
            end else if (r_state == ST_SHIFT) begin
                if (w_bitEnd) begin
                    if (r_bitCnt != 3'd0) begin
                        r_bitCnt <= r_bitCnt - 3'd1;
                        r_perCnt <= c_PER_LOAD;
                    end
                end else begin
                    r_perCnt <= r_perCnt - c_PW'(1);
                end
            end
        end
    end

    always_comb begin
        BitValid  = (r_state == ST_SHIFT);
        SerialOut = BitValid && r_codeOut[r_bitCnt];
        Busy      = (r_state != ST_IDLE) || !w_empty;
    end

    assign CodeOut    = r_codeOut;
    assign CodeValid  = r_codeValid;
    assign FrameStart = r_frameStart;

endmodule
`default_nettype wire

// File: tb/tb_hamming_tx_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_hamming_tx_encoder
// Brief    : Self-checking bench; instance 0 uses BIT_PERIOD=1, instance 1
//            uses BIT_PERIOD=3. Honours HAMMING_ERR_INJECT_EN when defined.
// Revision : 1.0  initial release
// ============================================================================
module tb_hamming_tx_encoder;

    localparam int DEPTH = 4;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [3:0] dataIn     [2];
    logic       dataValid  [2];
    logic       dataReady  [2];
    logic [6:0] codeOut    [2];
    logic       codeValid  [2];
    logic       serialOut  [2];
    logic       bitValid   [2];
    logic       frameStart [2];
    logic       busy       [2];
`ifdef HAMMING_ERR_INJECT_EN
    logic       injEn      [2];
    logic [2:0] injPos     [2];
`endif

    int nVec  = 0;
    int nFail = 0;
    int cyc   = 0;

    // Hand-computed Hamming(7,4) table {d3,d2,d1,d0,p2,p1,p0}
    logic [6:0] codeTab [16] = '{
        7'b0000000, 7'b0001011, 7'b0010101, 7'b0011110,
        7'b0100110, 7'b0101101, 7'b0110011, 7'b0111000,
        7'b1000111, 7'b1001100, 7'b1010010, 7'b1011001,
        7'b1100001, 7'b1101010, 7'b1110100, 7'b1111111
    };

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc++;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        hamming_tx_encoder #(
            .DEPTH      (DEPTH),
            .BIT_PERIOD ((gi == 0) ? 1 : 3)
        ) u_dut (
            .Clock      (Clock),
            .Reset      (Reset),
            .DataIn     (dataIn[gi]),
            .DataValid  (dataValid[gi]),
`ifdef HAMMING_ERR_INJECT_EN
            .InjectEn   (injEn[gi]),
            .InjectPos  (injPos[gi]),
`endif
            .DataReady  (dataReady[gi]),
            .CodeOut    (codeOut[gi]),
            .CodeValid  (codeValid[gi]),
            .SerialOut  (serialOut[gi]),
            .BitValid   (bitValid[gi]),
            .FrameStart (frameStart[gi]),
            .Busy       (busy[gi])
        );
    end

    function automatic int bpOf(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic logic [6:0] tbEncode(input int w);
        int d3, d2, d1, d0, p2, p1, p0;
        d3 = (w >> 3) & 1;
        d2 = (w >> 2) & 1;
        d1 = (w >> 1) & 1;
        d0 = w & 1;
        p2 = (d3 + d2 + d1) % 2;
        p1 = (d3 + d2 + d0) % 2;
        p0 = (d3 + d1 + d0) % 2;
        return 7'((w & 15) * 8 + p2 * 4 + p1 * 2 + p0);
    endfunction

    function automatic logic [6:0] tbMask(input logic en, input int pos);
        return (en && pos != 0) ? 7'(1 << (pos - 1)) : 7'd0;
    endfunction

    // Reference model: queue of accepted words, and the cycle offset into the
    // current frame (0 = strobe cycle, 7*bp = gap, 7*bp+1 = idle)
    int         mq [2][$];
    int         mphase [2] = '{8, 22};
    logic [6:0] mcode  [2] = '{7'd0, 7'd0};
    logic [6:0] mMask;
    bit         mPushOk;
    bit         mLoad;
    int         mWord;

    always @(posedge Clock or posedge Reset) begin
        for (int i = 0; i < 2; i++) begin
            if (Reset) begin
                mq[i].delete();
                mphase[i] = 7 * bpOf(i) + 1;
                mcode[i]  = 7'd0;
            end else begin
                mPushOk = dataValid[i] && (mq[i].size() < DEPTH);
                mLoad   = (mphase[i] == 7 * bpOf(i) + 1) && (mq[i].size() > 0);
                mMask   = 7'd0;
`ifdef HAMMING_ERR_INJECT_EN
                mMask   = tbMask(injEn[i], int'(injPos[i]));
`endif
                if (mLoad) begin
                    mWord     = mq[i].pop_front();
                    mcode[i]  = tbEncode(mWord) ^ mMask;
                    mphase[i] = 0;
                end else if (mphase[i] < 7 * bpOf(i) + 1) begin
                    mphase[i]++;
                end
                if (mPushOk) mq[i].push_back(int'(dataIn[i]));
            end
        end
    end

    int          cPh, cBp;
    logic        eBV, eSO;
    logic [12:0] cExp, cGot;

    always @(negedge Clock) begin
        for (int i = 0; i < 2; i++) begin
            cBp  = bpOf(i);
            cPh  = mphase[i];
            eBV  = (cPh < 7 * cBp);
            eSO  = 1'b0;
            if (eBV) eSO = mcode[i][6 - cPh / cBp];
            cExp = {mcode[i], cPh == 0, cPh == 0, eBV, eSO,
                    (cPh < 7 * cBp + 1) || (mq[i].size() != 0),
                    mq[i].size() < DEPTH};
            cGot = {codeOut[i], codeValid[i], frameStart[i], bitValid[i],
                    serialOut[i], busy[i], dataReady[i]};
            nVec++;
            if (cGot !== cExp) begin
                nFail++;
                $display("FAIL cycle %0d dut%0d {code,cv,fs,bv,so,busy,rdy}: got %b expected %b",
                         cyc, i, cGot, cExp);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic pushWord(input int i, input int w);
        bit ok;
        ok = 1'b0;
        dataIn[i]    = 4'(w);
        dataValid[i] = 1'b1;
        for (int n = 0; n < 400 && !ok; n++) begin
            ok = dataReady[i];
            @(posedge Clock);
            #1;
        end
        dataValid[i] = 1'b0;
        if (!ok) begin
            nVec++;
            nFail++;
            $display("FAIL push timeout dut%0d word %0d", i, w);
        end
    endtask

    task automatic waitCV(input int i, input logic [6:0] exp, input string name);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 400 && !seen; n++) begin
            @(negedge Clock);
            seen = codeValid[i];
        end
        if (seen) begin
            check(name, codeOut[i], exp);
        end else begin
            nVec++;
            nFail++;
            $display("FAIL %s: no CodeValid within 400 cycles on dut%0d", name, i);
        end
    endtask

    // Call at the CodeValid sample point; collects the 7 serial bits
    task automatic serialCheck(input int i, input logic [6:0] exp, input string name);
        logic [6:0] got;
        check({name, "_fs"}, frameStart[i], 1);
        got[6] = serialOut[i];
        for (int j = 5; j >= 0; j--) begin
            repeat (bpOf(i)) @(negedge Clock);
            got[j] = serialOut[i];
        end
        check(name, got, exp);
    endtask

    int  cvCyc [16];
    int  acc;
    int  nextW;
    bit  sawLow;
    bit  rdy;

    initial begin
        for (int i = 0; i < 2; i++) begin
            dataIn[i]    = 4'd0;
            dataValid[i] = 1'b0;
`ifdef HAMMING_ERR_INJECT_EN
            injEn[i]     = 1'b0;
            injPos[i]    = 3'd0;
`endif
        end
        repeat (3) @(posedge Clock);
        #1;
        check("rstA", {codeOut[0], codeValid[0], frameStart[0], bitValid[0],
                       serialOut[0], busy[0], dataReady[0]}, 13'b1);
        Reset = 1'b0;

        // Single word 1
        pushWord(0, 1);
        waitCV(0, 7'b0001011, "code1");
        serialCheck(0, 7'b0001011, "serial1");
        repeat (20) @(posedge Clock);
        #1;

        // All 16 values back to back, 9-cycle frame spacing
        fork
            begin
                for (int k = 0; k < 16; k++) pushWord(0, k);
            end
            begin
                for (int k = 0; k < 16; k++) begin
                    waitCV(0, codeTab[k], $sformatf("tab%0d", k));
                    cvCyc[k] = cyc;
                    if (k > 0) check($sformatf("spacing%0d", k), cvCyc[k] - cvCyc[k-1], 9);
                end
            end
        join
        repeat (20) @(posedge Clock);
        #1;

        // Simultaneous push and pop with three words buffered
        pushWord(0, 9);
        waitCV(0, codeTab[9], "ppHead");
        pushWord(0, 10);
        pushWord(0, 11);
        pushWord(0, 12);
        repeat (5) @(posedge Clock);
        #1;
        check("ppReadyBefore", dataReady[0], 1);
        dataIn[0]    = 4'd6;
        dataValid[0] = 1'b1;
        @(posedge Clock);
        #1;
        dataValid[0] = 1'b0;
        check("ppReadyAfter", dataReady[0], 1);
        check("ppPop", codeValid[0], 1);
        waitCV(0, codeTab[10], "pp10");
        waitCV(0, codeTab[11], "pp11");
        waitCV(0, codeTab[12], "pp12");
        waitCV(0, codeTab[6], "pp6");
        repeat (20) @(posedge Clock);
        #1;

`ifdef HAMMING_ERR_INJECT_EN
        injEn[0]  = 1'b1;
        injPos[0] = 3'd6;
        pushWord(0, 14);
        waitCV(0, 7'b1010100, "inj14p6");
        injPos[0] = 3'd1;
        pushWord(0, 3);
        waitCV(0, 7'b0011111, "inj3p1");
        injPos[0] = 3'd0;
        pushWord(0, 8);
        waitCV(0, 7'b1000111, "inj8p0");
        injEn[0]  = 1'b0;
        repeat (20) @(posedge Clock);
        #1;
`endif

        // DataValid held 8 cycles, BIT_PERIOD=3: DEPTH buffered + 1 in flight
        acc    = 0;
        nextW  = 0;
        sawLow = 1'b0;
        fork
            begin
                dataValid[1] = 1'b1;
                for (int c = 0; c < 8; c++) begin
                    dataIn[1] = 4'(nextW);
                    rdy = dataReady[1];
                    if (!rdy) sawLow = 1'b1;
                    @(posedge Clock);
                    #1;
                    if (rdy) begin
                        nextW++;
                        acc++;
                    end
                end
                dataValid[1] = 1'b0;
            end
            begin
                for (int k = 0; k < 5; k++) waitCV(1, codeTab[k], $sformatf("hold%0d", k));
            end
        join
        check("holdAccepted", acc, 5);
        check("holdReadyFell", sawLow, 1);
        repeat (40) @(posedge Clock);
        #1;

        // Reset during bit 3 of the frame for 13, with 7 still buffered
        pushWord(1, 13);
        pushWord(1, 7);
        waitCV(1, codeTab[13], "rst13");
        repeat (10) @(negedge Clock);
        #2;
        Reset = 1'b1;
        #1;
        check("asyncRst", {codeOut[1], codeValid[1], frameStart[1], bitValid[1],
                           serialOut[1], busy[1], dataReady[1]}, 13'b1);
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        repeat (5) @(posedge Clock);
        #1;
        check("rstFlushed", busy[1], 0);
        pushWord(1, 5);
        waitCV(1, 7'b0101101, "after5");
        serialCheck(1, 7'b0101101, "serial5");
        repeat (40) @(posedge Clock);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
